// File: rtl/param_pkg.sv
// Shared widths and the arbiter state encoding for the CPU data-bus arbiter.
package param_pkg;
  localparam int N_CPU     = 4;
  localparam int DBUS_AW   = 32;
  localparam int DBUS_DW   = 32;
  localparam int DBUS_ISEL = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/dbus_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first eligible bit at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] index
);
  logic [N-1:0] w_rot;
  int           w_sum;

  // Rotate so bit 0 of w_rot is the requester currently holding top priority.
  assign w_rot = N'({eligible, eligible} >> rr_ptr);

  always_comb begin
    valid = 1'b0;
    index = '0;
    w_sum = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = int'(rr_ptr) + k;
        if (w_sum >= N) w_sum = w_sum - N;
        valid = 1'b1;
        index = IW'(w_sum);
      end
    end
  end
endmodule

// File: rtl/dbus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream data-bus port among N_CPU masters.
// Optional watchdog on the downstream ack is enabled by defining DBUS_ARB_TIMEOUT_EN.
module dbus_rr_arbiter
  import param_pkg::*;
#(
  parameter int N_CPU          = param_pkg::N_CPU,
  parameter int DBUS_AW        = param_pkg::DBUS_AW,
  parameter int DBUS_DW        = param_pkg::DBUS_DW,
  parameter int DBUS_ISEL      = param_pkg::DBUS_ISEL,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CPU-1:0]              req_m2dbiu,
  input  logic [N_CPU*DBUS_AW-1:0]      adr_m2dbiu_flat,
  input  logic [N_CPU*DBUS_DW-1:0]      dat_m2dbiu_flat,
  input  logic [N_CPU-1:0]              we_m2dbiu,
  input  logic [N_CPU*DBUS_ISEL-1:0]    sel_m2dbiu_flat,
  output logic [N_CPU*DBUS_DW-1:0]      dat_dbiu2m_flat,
  output logic [N_CPU-1:0]              ack_dbiu2m,
  output logic [N_CPU-1:0]              err_dbiu2m,
  output logic                          req_arb2s,
  output logic [DBUS_AW-1:0]            adr_arb2s,
  output logic [DBUS_DW-1:0]            dat_arb2s,
  output logic                          we_arb2s,
  output logic [DBUS_ISEL-1:0]          sel_arb2s,
  input  logic [DBUS_DW-1:0]            dat_s2arb,
  input  logic                          ack_s2arb,
  output logic [$clog2(N_CPU)-1:0]      gnt_id,
  output logic                          busy
);
  localparam int IW = $clog2(N_CPU);
  localparam int FW = N_CPU * DBUS_DW;

  arb_state_t       r_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [N_CPU-1:0] r_holdoff;

  logic [N_CPU-1:0] w_elig;
  logic             w_vld;
  logic [IW-1:0]    w_idx;
  logic [N_CPU-1:0] w_gnt_oh;
  logic [IW-1:0]    w_ptr_nxt;

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign err_dbiu2m = '0;
`endif

  // The master just served is masked for one IDLE cycle so it can drop its request.
  assign w_elig    = req_m2dbiu & ~r_holdoff;
  assign w_gnt_oh  = N_CPU'(1) << gnt_id;
  assign w_ptr_nxt = (gnt_id == IW'(N_CPU - 1)) ? '0 : gnt_id + 1'b1;

  rr_pick #(.N(N_CPU), .IW(IW)) u_pick (
    .eligible (w_elig),
    .rr_ptr   (r_rr_ptr),
    .valid    (w_vld),
    .index    (w_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_rr_ptr        <= '0;
      r_holdoff       <= '0;
      gnt_id          <= '0;
      busy            <= 1'b0;
      req_arb2s       <= 1'b0;
      adr_arb2s       <= '0;
      dat_arb2s       <= '0;
      we_arb2s        <= 1'b0;
      sel_arb2s       <= '0;
      ack_dbiu2m      <= '0;
      dat_dbiu2m_flat <= '0;
`ifdef DBUS_ARB_TIMEOUT_EN
      err_dbiu2m      <= '0;
      r_tmo           <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_holdoff <= '0;
          if (w_vld) begin
            gnt_id    <= w_idx;
            adr_arb2s <= adr_m2dbiu_flat[w_idx*DBUS_AW +: DBUS_AW];
            dat_arb2s <= dat_m2dbiu_flat[w_idx*DBUS_DW +: DBUS_DW];
            we_arb2s  <= we_m2dbiu[w_idx];
            sel_arb2s <= sel_m2dbiu_flat[w_idx*DBUS_ISEL +: DBUS_ISEL];
            req_arb2s <= 1'b1;
            busy      <= 1'b1;
            r_state   <= ISSUE;
`ifdef DBUS_ARB_TIMEOUT_EN
            r_tmo     <= '0;
`endif
          end
        end
        ISSUE: begin
          // A real ack wins over a watchdog expiry in the same cycle.
          if (ack_s2arb) begin
            req_arb2s       <= 1'b0;
            ack_dbiu2m      <= w_gnt_oh;
            dat_dbiu2m_flat <= FW'(dat_s2arb) << (gnt_id * DBUS_DW);
            r_state         <= RESP;
          end
`ifdef DBUS_ARB_TIMEOUT_EN
          else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            req_arb2s       <= 1'b0;
            ack_dbiu2m      <= w_gnt_oh;
            err_dbiu2m      <= w_gnt_oh;
            dat_dbiu2m_flat <= '0;
            r_state         <= RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        RESP: begin
          ack_dbiu2m      <= '0;
          dat_dbiu2m_flat <= '0;
`ifdef DBUS_ARB_TIMEOUT_EN
          err_dbiu2m      <= '0;
`endif
          busy            <= 1'b0;
          r_rr_ptr        <= w_ptr_nxt;
          r_holdoff       <= w_gnt_oh;
          r_state         <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// Bench for dbus_rr_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_dbus_rr_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 8;
`ifdef DBUS_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] adr = '0;
  logic [N*DW-1:0] wdat = '0;
  logic [N-1:0]    we = '0;
  logic [N*SW-1:0] sel = '0;
  logic [N*DW-1:0] rdat_flat;
  logic [N-1:0]    ack_m, err_m;
  logic            req_s;
  logic [AW-1:0]   adr_s;
  logic [DW-1:0]   dat_s;
  logic            we_s;
  logic [SW-1:0]   sel_s;
  logic [DW-1:0]   dat_s2arb = '0;
  logic            ack_s2arb = 1'b0;
  logic [1:0]      gnt_id;
  logic            busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  dbus_rr_arbiter #(.N_CPU(N), .DBUS_AW(AW), .DBUS_DW(DW), .DBUS_ISEL(SW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(rst),
    .req_m2dbiu(req), .adr_m2dbiu_flat(adr), .dat_m2dbiu_flat(wdat),
    .we_m2dbiu(we), .sel_m2dbiu_flat(sel),
    .dat_dbiu2m_flat(rdat_flat), .ack_dbiu2m(ack_m), .err_dbiu2m(err_m),
    .req_arb2s(req_s), .adr_arb2s(adr_s), .dat_arb2s(dat_s), .we_arb2s(we_s), .sel_arb2s(sel_s),
    .dat_s2arb(dat_s2arb), .ack_s2arb(ack_s2arb),
    .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level model: who owns the bus, whether it is answering, and who is masked.
  int          m_owner = -1, m_prio = 0, m_hold = -1, m_waited = 0, m_last = 0;
  bit          m_resp = 1'b0, m_err = 1'b0;
  logic [31:0] m_adr = '0, m_dat = '0, m_cap = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_sel = '0;
  int          pick;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_prio = 0; m_hold = -1; m_waited = 0; m_last = 0;
      m_resp = 1'b0; m_err = 1'b0; m_adr = '0; m_dat = '0; m_cap = '0; m_we = 1'b0; m_sel = '0;
    end else if (m_resp) begin
      m_prio = (m_owner + 1) % N;
      m_hold = m_owner;
      m_owner = -1; m_resp = 1'b0; m_err = 1'b0;
    end else if (m_owner >= 0) begin
      if (ack_s2arb) begin
        m_cap = dat_s2arb; m_resp = 1'b1;
      end else begin
        m_waited++;
        if (TMO_EN && m_waited == TMO) begin
          m_cap = '0; m_resp = 1'b1; m_err = 1'b1;
        end
      end
    end else begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && req[(m_prio + k) % N] && ((m_prio + k) % N) != m_hold) pick = (m_prio + k) % N;
      m_hold = -1;
      if (pick >= 0) begin
        m_owner = pick; m_last = pick; m_waited = 0;
        m_adr = adr[pick*AW +: AW]; m_dat = wdat[pick*DW +: DW];
        m_we = we[pick]; m_sel = sel[pick*SW +: SW];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_arb2s", req_s, (m_owner >= 0 && !m_resp));
      check("busy", busy, (m_owner >= 0));
      check("gnt_id", gnt_id, m_last);
      check("adr_arb2s", adr_s, m_adr);
      check("dat_arb2s", dat_s, m_dat);
      check("we_arb2s", we_s, m_we);
      check("sel_arb2s", sel_s, m_sel);
      check("ack_dbiu2m", ack_m, m_resp ? (4'b1 << m_owner) : 4'b0);
      check("err_dbiu2m", err_m, (m_resp && m_err) ? (4'b1 << m_owner) : 4'b0);
      check("dat_dbiu2m", rdat_flat, m_resp ? (128'(m_cap) << (32 * m_owner)) : 128'b0);
    end
  end

  task automatic rand_fields(input int i);
    adr[i*AW +: AW] = $urandom;
    wdat[i*DW +: DW] = $urandom;
    we[i] = 1'($urandom_range(0, 1));
    sel[i*SW +: SW] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int grants[$];
    int issue_cyc;
    bit got;

    // Reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_req", req_s, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack_m, 0);
    check("rst_gnt", gnt_id, 0);
    rst = 1'b0;

    // Single read from CPU1, slave answers two cycles after the request appears
    @(negedge clk);
    req[1] = 1'b1; adr[1*AW +: AW] = 32'h100; we[1] = 1'b0; sel[1*SW +: SW] = 4'hF;
    @(negedge clk);
    check("t1_req", req_s, 1); check("t1_adr", adr_s, 32'h100); check("t1_gnt", gnt_id, 1);
    @(negedge clk);
    check("t1_req_hold", req_s, 1);
    ack_s2arb = 1'b1; dat_s2arb = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_ack", ack_m, 4'b0010); check("t1_slice", rdat_flat[63:32], 32'hDEADBEEF);
    ack_s2arb = 1'b0; req[1] = 1'b0;
    @(negedge clk);
    check("t1_ack_gone", ack_m, 0); check("t1_idle", busy, 0);

    // All four held together after a fresh reset: order 0,1,2,3,0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'hF; ack_s2arb = 1'b1;
    for (int t = 0; t < 60 && grants.size() < 5; t++) begin
      @(negedge clk);
      dat_s2arb = $urandom;
      for (int i = 0; i < N; i++) if (ack_m[i]) grants.push_back(i);
      if (grants.size() == 5) req = '0;
    end
    check("t2_count", grants.size(), 5);
    for (int g = 0; g < grants.size(); g++) check("t2_order", grants[g], g % 4);
    repeat (3) @(negedge clk);

    // Hold-off: CPU2 keeps its request one cycle past its ack
    @(negedge clk);
    req[2] = 1'b1;
    @(negedge clk);
    check("t3_req", req_s, 1); check("t3_gnt", gnt_id, 2);
    @(negedge clk);
    check("t3_ack", ack_m, 4'b0100);
    @(negedge clk);
    check("t3_idle", busy, 0);
    @(negedge clk);
    check("t3_masked", req_s, 0);
    @(negedge clk);
    check("t3_regrant", req_s, 1);
    @(negedge clk);
    check("t3_ack2", ack_m, 4'b0100);
    req[2] = 1'b0; ack_s2arb = 1'b0;
    repeat (2) @(negedge clk);

    // Write from CPU3; the latched fields must survive the master changing its inputs
    req[3] = 1'b1; we[3] = 1'b1; sel[3*SW +: SW] = 4'hF;
    wdat[3*DW +: DW] = 32'h12345678; adr[3*AW +: AW] = 32'h200;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("t4_req", req_s, 1); check("t4_adr", adr_s, 32'h200); check("t4_dat", dat_s, 32'h12345678);
      check("t4_we", we_s, 1); check("t4_sel", sel_s, 4'hF);
      rand_fields(3);
    end
    ack_s2arb = 1'b1;
    @(negedge clk);
    check("t4_ack", ack_m, 4'b1000);
    req[3] = 1'b0; ack_s2arb = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of ISSUE, then CPU0 is served normally
    req[2] = 1'b1;
    @(negedge clk);
    check("t5_req", req_s, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req[2] = 1'b0;
    check("t5_req0", req_s, 0); check("t5_busy0", busy, 0); check("t5_gnt0", gnt_id, 0);
    check("t5_adr0", adr_s, 0); check("t5_dat0", dat_s, 0); check("t5_sel0", sel_s, 0);
    check("t5_ack0", ack_m, 0);
    @(negedge clk);
    req[0] = 1'b1; ack_s2arb = 1'b1; dat_s2arb = 32'hA5A5_0001;
    @(negedge clk);
    check("t5_req", req_s, 1); check("t5_gnt", gnt_id, 0);
    @(negedge clk);
    check("t5_ack", ack_m, 4'b0001); check("t5_slice", rdat_flat[31:0], 32'hA5A5_0001);
    req[0] = 1'b0; ack_s2arb = 1'b0;

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ack_s2arb = ($urandom_range(0, 2) == 0);
      dat_s2arb = $urandom;
      for (int i = 0; i < N; i++) begin
        if (ack_m[i]) begin
          if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          rand_fields(i);
        end
        if ($urandom_range(0, 2) == 0) rand_fields(i);
      end
    end

    // Drain
    @(negedge clk);
    req = '0; ack_s2arb = 1'b1;
    repeat (6) @(negedge clk);
    ack_s2arb = 1'b0;

`ifdef DBUS_ARB_TIMEOUT_EN
    // Watchdog: slave never answers, then a late ack must be ignored
    @(negedge clk);
    req[1] = 1'b1;
    issue_cyc = 0; got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (req_s) issue_cyc++;
      if (ack_m != 0) begin
        got = 1'b1;
        check("tmo_ack", ack_m, 4'b0010); check("tmo_err", err_m, 4'b0010);
        check("tmo_dat", rdat_flat, 0);
      end
    end
    check("tmo_seen", got, 1);
    check("tmo_cycles", issue_cyc, TMO);
    req[1] = 1'b0; ack_s2arb = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("tmo_late", ack_m, 0);
    end
    ack_s2arb = 1'b0;
`else
    issue_cyc = 0; got = 1'b0;
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
